// File: rtl/sdram_arbiter_if.sv
// ============================================================================
// Module   : sdram_arbiter_if
// Purpose  : Requester-side and SDRAM-side bus bundle for sdram_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdram_arbiter_if #(
  parameter int NPORT = 4
);
  // Requester side: one command slot per port, shared read-data return.
  logic [NPORT-1:0]             req_read;
  logic [NPORT-1:0]             req_write;
  logic [NPORT-1:0][22:0]       req_addr;
  logic [NPORT-1:0][31:0]       req_writedata;
  logic [31:0]                  req_readdata;
  logic [NPORT-1:0]             req_finished;
  logic [NPORT-1:0]             req_error;

  // SDRAM bus side: one command in flight at a time.
  logic                         sdram_read;
  logic                         sdram_write;
  logic [22:0]                  sdram_addr;
  logic [31:0]                  sdram_writedata;
  logic [31:0]                  sdram_readdata;
  logic                         sdram_finished;

  // Arbiter view.
  modport slave (
    input  req_read, req_write, req_addr, req_writedata,
    output req_readdata, req_finished, req_error,
    output sdram_read, sdram_write, sdram_addr, sdram_writedata,
    input  sdram_readdata, sdram_finished
  );

  // Requester / SDRAM model view.
  modport master (
    output req_read, req_write, req_addr, req_writedata,
    input  req_readdata, req_finished, req_error,
    input  sdram_read, sdram_write, sdram_addr, sdram_writedata,
    output sdram_readdata, sdram_finished
  );
endinterface

`default_nettype wire

// File: rtl/sdram_arbiter.sv
// ============================================================================
// Module   : sdram_arbiter
// Purpose  : Round-robin arbiter granting one of NPORT requesters access to a
//            single SDRAM command bus, with per-transaction timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_arbiter #(
  parameter int NPORT   = 4,
  parameter int TIMEOUT = 4096
) (
  input  wire                        i_clk,
  input  wire                        i_rst,
  input  wire  [NPORT-1:0]           port_enable,
  sdram_arbiter_if.slave             bus,
  output logic                       busy,
  output logic [$clog2(NPORT)-1:0]   grant_id
);

  localparam int PW = $clog2(NPORT);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_TERM = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     grant_q, grant_d;
  logic [PW-1:0]     last_grant_q, last_grant_d;
  logic              sdram_read_q, sdram_read_d;
  logic              sdram_write_q, sdram_write_d;
  logic [22:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [NPORT-1:0]  finished_q, finished_d;
  logic [NPORT-1:0]  error_q, error_d;
  logic [CW-1:0]     timeout_q, timeout_d;

  logic [NPORT-1:0]  req_vec;
  logic              pick_valid;
  logic [PW-1:0]     pick_idx;
  logic [PW-1:0]     cand;

  assign req_vec = port_enable & (bus.req_read | bus.req_write);

  // Round-robin search: first requesting port after the last one served.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NPORT; k++) begin
      cand = last_grant_q + PW'(k + 1);
      if (!pick_valid && req_vec[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    sdram_read_d  = sdram_read_q;
    sdram_write_d = sdram_write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    finished_d    = '0;
    error_d       = '0;
    timeout_d     = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d       = S_BUSY;
          grant_d       = pick_idx;
          addr_d        = bus.req_addr[pick_idx];
          wdata_d       = bus.req_writedata[pick_idx];
          // A port raising both read and write is served as a write.
          sdram_write_d = bus.req_write[pick_idx];
          sdram_read_d  = !bus.req_write[pick_idx];
          timeout_d     = '0;
        end
      end

      S_BUSY: begin
        if (bus.sdram_finished || (timeout_q == TO_TERM)) begin
          state_d              = S_DONE;
          sdram_read_d         = 1'b0;
          sdram_write_d        = 1'b0;
          addr_d               = '0;
          wdata_d              = '0;
          last_grant_d         = grant_q;
          finished_d[grant_q]  = 1'b1;
          if (bus.sdram_finished) begin
            if (sdram_read_q) begin
              rdata_d = bus.sdram_readdata;
            end
          end else begin
            error_d[grant_q] = 1'b1;
          end
        end else begin
          timeout_d = timeout_q + CW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      last_grant_q  <= PW'(NPORT - 1);
      sdram_read_q  <= 1'b0;
      sdram_write_q <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      finished_q    <= '0;
      error_q       <= '0;
      timeout_q     <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      sdram_read_q  <= sdram_read_d;
      sdram_write_q <= sdram_write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      finished_q    <= finished_d;
      error_q       <= error_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.sdram_read      = sdram_read_q;
  assign bus.sdram_write     = sdram_write_q;
  assign bus.sdram_addr      = addr_q;
  assign bus.sdram_writedata = wdata_q;
  assign bus.req_readdata    = rdata_q;
  assign bus.req_finished    = finished_q;
  assign bus.req_error       = error_q;
  assign busy                = (state_q != S_IDLE);
  assign grant_id            = grant_q;

`ifndef SYNTHESIS
  a_cmd_exclusive : assert property (@(posedge i_clk) disable iff (i_rst)
    !(bus.sdram_read && bus.sdram_write));
  a_finish_onehot : assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0(bus.req_finished));
`endif

endmodule

`default_nettype wire
